jpeg_quant_zigzag: RTL and testbench

Downstream neighbour of the 2-D DCT stage in the JPEG encoder. Captures one 8x8 block of DCT coefficients in a single cycle and quantizes each coefficient by reciprocal multiplication with rounding. Emits the 64 results serially in zigzag order over a valid/ready stream to the run-length/Huffman stage. The quantization table is runtime-writable.

---
 rtl/jpeg_pkg.sv | 33 +++
 rtl/jpeg_quant_mul.sv | 64 ++++++
 rtl/jpeg_quant_zigzag.sv | 104 ++++++++++
 tb/tb_jpeg_quant_zigzag.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantize/zigzag stage: scan order, default luma reciprocals,
// coefficient width and the controller state type.
package jpeg_pkg;

  localparam int unsigned COEF_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fsm_t;

  // Raster index of each zigzag position.
  localparam int unsigned ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // round(65536/Q) for the standard luminance quantization table, raster order.
  localparam int unsigned STD_LUMA_RECIP [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

endpackage

// File: rtl/jpeg_quant_mul.sv
// Two-stage quantizer pipeline: operand register, then reciprocal multiply with
// round-half-up into the output register. The whole pipeline freezes when en is low.
module jpeg_quant_mul
  import jpeg_pkg::*;
#(
  parameter int unsigned RECIP_W = 17
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic [RECIP_W-1:0]       in_recip,
  input  logic [5:0]               in_index,
  output logic                     out_valid,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [5:0]               out_index,
  output logic                     out_last
);

  localparam int unsigned ProdW = COEF_W + RECIP_W + 1;

  logic                     s1_valid_q;
  logic signed [COEF_W-1:0] s1_coef_q;
  logic [RECIP_W-1:0]       s1_recip_q;
  logic [5:0]               s1_index_q;

  logic signed [ProdW-1:0]  coef_ext, recip_ext, prod, rnd;
  logic signed [COEF_W-1:0] q;

  // Reciprocal is unsigned; the extra zero bit keeps it positive in the signed product.
  assign coef_ext  = ProdW'(s1_coef_q);
  assign recip_ext = ProdW'({1'b0, s1_recip_q});
  assign prod      = coef_ext * recip_ext;
  assign rnd       = prod + ProdW'(32768);
  assign q         = COEF_W'(rnd >>> 16);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_coef_q  <= '0;
      s1_recip_q <= '0;
      s1_index_q <= '0;
      out_valid  <= 1'b0;
      out_coef   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_coef_q  <= in_coef;
        s1_recip_q <= in_recip;
        s1_index_q <= in_index;
      end
      out_valid <= s1_valid_q;
      out_last  <= s1_valid_q && (s1_index_q == 6'd63);
      if (s1_valid_q) begin
        out_coef  <= q;
        out_index <= s1_index_q;
      end
    end
  end

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// Block quantizer: captures an 8x8 DCT block, quantizes by reciprocal multiply and streams
// the 64 results out in zigzag order over valid/ready.
module jpeg_quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int unsigned RECIP_W = 17
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic signed [COEF_W-1:0] coef_in [0:63],
  input  logic                     qt_we,
  input  logic [5:0]               qt_addr,
  input  logic [RECIP_W-1:0]       qt_recip,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [5:0]               out_index,
  output logic                     out_last,
  output logic                     err_overrun
);

  fsm_t                     state_q, state_d;
  logic [5:0]               k_q, k_d;
  logic                     err_q;
  logic signed [COEF_W-1:0] cbuf_q [64];
  logic [RECIP_W-1:0]       qtab_q [64];
  logic                     accept, issue, advance;
  logic [5:0]               raster;

  assign blk_ready   = (state_q == StIdle);
  assign accept      = blk_valid && (state_q == StIdle);
  assign advance     = ~out_valid | out_ready;
  assign raster      = 6'(ZIGZAG[k_q]);
  assign err_overrun = err_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (blk_valid) begin
          state_d = StRun;
          k_d     = '0;
        end
      end
      StRun: begin
        if (advance) begin
          issue = 1'b1;
          k_d   = k_q + 6'd1;
          if (k_q == 6'd63) state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_valid && out_ready && out_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (blk_valid && (state_q != StIdle)) err_q <= 1'b1;
    end
  end

  // Coefficient buffer holds no state worth resetting; it is always loaded before use.
  always_ff @(posedge clock) begin
    if (accept) cbuf_q <= coef_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) qtab_q[i] <= RECIP_W'(STD_LUMA_RECIP[i]);
    end else if (qt_we && (state_q == StIdle)) begin
      qtab_q[qt_addr] <= qt_recip;
    end
  end

  jpeg_quant_mul #(
    .RECIP_W (RECIP_W)
  ) u_mul (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (advance),
    .in_valid  (issue),
    .in_coef   (cbuf_q[raster]),
    .in_recip  (qtab_q[raster]),
    .in_index  (k_q),
    .out_valid (out_valid),
    .out_coef  (out_coef),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed bench for jpeg_quant_zigzag: timing, rounding, stalls, overrun, table writes, reset.
module tb_jpeg_quant_zigzag;

  logic                clock;
  logic                reset_n;
  logic                blk_valid;
  logic                blk_ready;
  logic signed [7:0]   coef_in [0:63];
  logic                qt_we;
  logic [5:0]          qt_addr;
  logic [16:0]         qt_recip;
  logic                out_valid;
  logic                out_ready;
  logic signed [7:0]   out_coef;
  logic [5:0]          out_index;
  logic                out_last;
  logic                err_overrun;

  int                  n_vec;
  int                  n_bad;
  int                  cyc;
  int                  n_got;
  int                  zz [64];
  logic signed [7:0]   got_coef [64];
  int                  got_cyc [64];

  jpeg_quant_zigzag #(
    .RECIP_W (17)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .coef_in     (coef_in),
    .qt_we       (qt_we),
    .qt_addr     (qt_addr),
    .qt_recip    (qt_recip),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_coef    (out_coef),
    .out_index   (out_index),
    .out_last    (out_last),
    .err_overrun (err_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_all(input logic [16:0] r);
    for (int i = 0; i < 64; i++) begin
      qt_we    = 1'b1;
      qt_addr  = 6'(i);
      qt_recip = r;
      tick();
    end
    qt_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) coef_in[i] = 8'(i - 32);
  endtask

  // Runs one block from IDLE. Cycle 0 is the accept cycle. Optional events (-1 = off):
  // ovr_at pulses blk_valid with foreign data, we_at writes entry 0 = 1, abort_at resets.
  task automatic run_block(input bit rnd, input int ovr_at, input int we_at, input int abort_at);
    logic signed [7:0] saved [64];
    logic signed [7:0] hc;
    logic [5:0]        hi;
    logic              hl;
    bit                stalled;
    bit                aborted;
    int                guard;
    for (int i = 0; i < 64; i++) saved[i] = coef_in[i];
    n_got = 0; stalled = 0; aborted = 0; guard = 0;
    hc = '0; hi = '0; hl = 1'b0;
    cyc       = 0;
    blk_valid = 1'b1;
    qt_we     = (we_at == 0);
    qt_addr   = '0;
    qt_recip  = 17'd1;
    out_ready = 1'b1;
    tick();
    cyc = 1;
    while (n_got < 64 && guard < 1000 && !aborted) begin
      blk_valid = (cyc == ovr_at);
      qt_we     = (cyc == we_at);
      for (int i = 0; i < 64; i++) coef_in[i] = (cyc == ovr_at) ? 8'sd77 : saved[i];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1) check("busy_ready", blk_ready, 0);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_coef", out_coef, hc);
        check("stall_index", out_index, hi);
        check("stall_last", out_last, hl);
      end
      if (cyc == abort_at) begin
        reset_n = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_ready", blk_ready, 1);
        check("rst_err", err_overrun, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("post_rst_valid", out_valid, 0);
        end
        aborted = 1;
      end else begin
        if (out_valid && out_ready) begin
          got_coef[n_got] = out_coef;
          got_cyc[n_got]  = cyc;
          check($sformatf("index_k%0d", n_got), out_index, n_got);
          check($sformatf("last_k%0d", n_got), out_last, (n_got == 63));
          n_got++;
          stalled = 0;
        end else if (out_valid) begin
          stalled = 1;
          hc = out_coef; hi = out_index; hl = out_last;
        end else begin
          stalled = 0;
        end
        tick();
        cyc++;
        guard++;
      end
    end
    blk_valid = 1'b0;
    qt_we     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) coef_in[i] = saved[i];
    if (!aborted) begin
      check("blk_count", n_got, 64);
      check("ready_after", blk_ready, 1);
    end
  endtask

  task automatic check_ramp(input string tag);
    for (int k = 0; k < 64; k++) check($sformatf("%s_k%0d", tag, k), got_coef[k], zz[k] - 32);
  endtask

  initial begin
    int n;
    n_vec = 0; n_bad = 0; cyc = 0; n_got = 0;
    // Independent zigzag walk over the anti-diagonals.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
    reset_n = 1'b1; blk_valid = 1'b0; qt_we = 1'b0; qt_addr = '0; qt_recip = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) coef_in[i] = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_blk_ready", blk_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_overrun", err_overrun, 0);
    check("rst_out_coef", out_coef, 0);
    check("rst_out_index", out_index, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Q=1 everywhere: output equals the raster coefficient.
    write_all(17'd65536);
    load_ramp();
    run_block(0, -1, -1, -1);
    check("t1_first_cycle", got_cyc[0], 3);
    check("t1_last_cycle", got_cyc[63], 66);
    check("t1_k0", got_coef[0], -32);
    check("t1_k1", got_coef[1], -31);
    check("t1_k2", got_coef[2], -24);
    check("t1_k3", got_coef[3], -16);
    check("t1_k63", got_coef[63], 31);
    check_ramp("t1");

    // Random backpressure: same sequence, stability checked inside run_block.
    run_block(1, -1, -1, -1);
    check_ramp("t2");

    // Q=16: rounding half toward +inf.
    write_all(17'd4096);
    for (int i = 0; i < 64; i++) coef_in[i] = '0;
    coef_in[0] = 8'sd24;
    coef_in[1] = -8'sd24;
    coef_in[8] = -8'sd128;
    run_block(0, -1, -1, -1);
    check("t3_k0", got_coef[0], 2);
    check("t3_k1", got_coef[1], -1);
    check("t3_k2", got_coef[2], -8);
    check("t3_k63", got_coef[63], 0);
    check("t3_err", err_overrun, 0);

    // Overrun in cycle 10: dropped, sticky flag, block unaffected.
    write_all(17'd65536);
    load_ramp();
    run_block(0, 10, -1, -1);
    check("t4_err", err_overrun, 1);
    check_ramp("t4");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_extra", out_valid, 0);
    end

    // Table write during RUN is ignored.
    run_block(0, -1, 5, -1);
    check("t5_k0", got_coef[0], -32);
    check("t5_err_sticky", err_overrun, 1);

    // Same write alongside blk_valid in IDLE lands and is used: (-32+32768)>>>16 = 0.
    run_block(0, -1, 0, -1);
    check("t6_k0", got_coef[0], 0);
    check("t6_k1", got_coef[1], -31);

    // Reset mid-block, then a clean block against the default luma table.
    run_block(0, -1, -1, 30);
    check("t7_ready", blk_ready, 1);
    run_block(0, -1, -1, -1);
    check("t8_first_cycle", got_cyc[0], 3);
    check("t8_k0", got_coef[0], -2);
    check("t8_k1", got_coef[1], -3);
    check("t8_k2", got_coef[2], -2);
    check("t8_k63", got_coef[63], 0);
    check("t8_err", err_overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
